// File: rtl/packet_header_framer_if.sv
// Purpose : header hand-off bundle between packet_header_framer and the
//           protocol/session classifier.
// Signals : hdr_valid   framer -> classifier, header fields valid
//           hdr_ready   classifier -> framer, header accepted this cycle
//           hdr_port    framer -> classifier, 16-bit destination port
//           hdr_session framer -> classifier, 8-bit session id
// Handshake: a header transfers on every clk edge where hdr_valid & hdr_ready
//            are both 1. Once hdr_valid is raised, hdr_valid, hdr_port and
//            hdr_session hold until that transfer. hdr_ready may be driven
//            freely and is ignored while hdr_valid is 0.
interface packet_header_framer_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [15:0] hdr_port;
  logic [7:0]  hdr_session;

  modport master (
    output hdr_valid,
    output hdr_port,
    output hdr_session,
    input  hdr_ready
  );

  modport slave (
    input  hdr_valid,
    input  hdr_port,
    input  hdr_session,
    output hdr_ready
  );
endinterface

// File: rtl/packet_header_framer.sv
// Purpose : hunts a 1-bit serial stream for a sync word, frames a fixed-length
//           packet behind it, deserialises the destination port and session id
//           and offers them as one parallel header over a valid/ready
//           handshake. Keeps a wrapping packet count and a saturating count of
//           headers dropped because the previous one was still pending.
// Ports   : clk, rst_n    clock, synchronous active-low reset
//           data_in       serial data bit
//           data_en       data_in is valid this cycle
//           hdr_if        header handshake (master side)
//           pkt_start     1-cycle pulse after the sync word matched
//           pkt_done      1-cycle pulse after the last packet bit was consumed
//           in_packet     high while framing a packet
//           pkt_cnt       packets framed, wraps
//           overrun_cnt   headers dropped, saturates at 255
//           dbg_state     FSM state (0 = HUNT, 1 = FRAME)
module packet_header_framer #(
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
  parameter int unsigned       PKT_BITS  = 256,
  parameter int unsigned       PORT_OFS  = 64,
  parameter int unsigned       SESS_OFS  = 136
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_in,
  input  logic                          data_en,
  packet_header_framer_if.master        hdr_if,
  output logic                          pkt_start,
  output logic                          pkt_done,
  output logic                          in_packet,
  output logic [31:0]                   pkt_cnt,
  output logic [7:0]                    overrun_cnt,
  output logic                          dbg_state
);

  localparam logic [15:0] PORT_FIRST = 16'(PORT_OFS);
  localparam logic [15:0] PORT_LAST  = 16'(PORT_OFS + 15);
  localparam logic [15:0] SESS_FIRST = 16'(SESS_OFS);
  localparam logic [15:0] SESS_LAST  = 16'(SESS_OFS + 7);
  localparam logic [15:0] IDX_LAST   = 16'(PKT_BITS - 1);

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sync_q, sync_d, sync_shift;
  logic [15:0]       idx_q, idx_d;
  logic [15:0]       port_sr_q, port_sr_d;
  logic [7:0]        sess_sr_q, sess_sr_d;
  logic [15:0]       hdr_port_q, hdr_port_d;
  logic [7:0]        hdr_sess_q, hdr_sess_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              publish;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sync_q     <= '0;
      idx_q      <= '0;
      port_sr_q  <= '0;
      sess_sr_q  <= '0;
      hdr_port_q <= '0;
      hdr_sess_q <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      idx_q      <= idx_d;
      port_sr_q  <= port_sr_d;
      sess_sr_q  <= sess_sr_d;
      hdr_port_q <= hdr_port_d;
      hdr_sess_q <= hdr_sess_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    idx_d      = idx_q;
    port_sr_d  = port_sr_q;
    sess_sr_d  = sess_sr_q;
    hdr_port_d = hdr_port_q;
    hdr_sess_d = hdr_sess_q;
    valid_d    = valid_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    ovr_d      = ovr_q;
    publish    = 1'b0;
    sync_shift = {sync_q[SYNC_W-2:0], data_in};

    // Bit-level framing only moves on enabled cycles; the pulse clears above
    // and the handshake below run every cycle.
    if (data_en) begin
      case (state_q)
        HUNT: begin
          sync_d = sync_shift;
          // Compare the post-shift window so overlapping matches are found.
          if (sync_shift == SYNC_WORD) begin
            state_d = FRAME;
            idx_d   = '0;
            start_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end
        end
        FRAME: begin
          idx_d = idx_q + 16'd1;
          if (idx_q >= PORT_FIRST && idx_q <= PORT_LAST) begin
            port_sr_d = {port_sr_q[14:0], data_in};
          end
          if (idx_q >= SESS_FIRST && idx_q <= SESS_LAST) begin
            sess_sr_d = {sess_sr_q[6:0], data_in};
          end
          // The last session bit completes the header; port bits precede it.
          if (idx_q == SESS_LAST) begin
            publish = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = HUNT;
            // Force a fresh full sync word before the next packet.
            sync_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A publish while a header is pending replaces it only if the pending
    // one is being accepted in this same cycle; otherwise the new one is lost.
    if (publish) begin
      if (!valid_q || hdr_if.hdr_ready) begin
        hdr_port_d = port_sr_d;
        hdr_sess_d = sess_sr_d;
        valid_d    = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end else if (valid_q && hdr_if.hdr_ready) begin
      valid_d = 1'b0;
    end
  end

  assign hdr_if.hdr_valid   = valid_q;
  assign hdr_if.hdr_port    = hdr_port_q;
  assign hdr_if.hdr_session = hdr_sess_q;
  assign pkt_start          = start_q;
  assign pkt_done           = done_q;
  assign in_packet          = (state_q == FRAME);
  assign pkt_cnt            = cnt_q;
  assign overrun_cnt        = ovr_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_packet_header_framer.sv
module tb_packet_header_framer;
  localparam int PKT_BITS = 256;
  localparam int PORT_OFS = 64;
  localparam int SESS_OFS = 136;
  localparam logic [7:0] SYNC = 8'hA5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic        data_en = 1'b0;
  logic        pkt_start, pkt_done, in_packet, dbg_state;
  logic [31:0] pkt_cnt;
  logic [7:0]  overrun_cnt;

  packet_header_framer_if hif();

  packet_header_framer #(
    .SYNC_W(8), .SYNC_WORD(8'hA5), .PKT_BITS(PKT_BITS),
    .PORT_OFS(PORT_OFS), .SESS_OFS(SESS_OFS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_en(data_en),
    .hdr_if(hif), .pkt_start(pkt_start), .pkt_done(pkt_done),
    .in_packet(in_packet), .pkt_cnt(pkt_cnt), .overrun_cnt(overrun_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int gap_mode = 0;

  logic        bits_q[$];
  int          edge_q[$];
  int          start_q[$], done_q[$], pub_q[$];
  logic [23:0] acc_q[$];
  int          stab_err = 0;
  int          stab_base = 0;

  int          exp_start_q[$], exp_done_q[$], exp_pub_q[$];
  logic [23:0] exp_q[$];
  int          exp_ovr;

  logic        prev_valid = 1'b0;
  logic        prev_acc = 1'b0;
  logic [23:0] prev_hdr = '0;

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (pkt_start) start_q.push_back(cyc);
    if (pkt_done) done_q.push_back(cyc);
    if (hif.hdr_valid && !prev_valid) pub_q.push_back(cyc);
    if (hif.hdr_valid && prev_valid && !prev_acc &&
        {hif.hdr_port, hif.hdr_session} != prev_hdr)
      stab_err <= stab_err + 1;
    if (hif.hdr_valid && hif.hdr_ready) acc_q.push_back({hif.hdr_port, hif.hdr_session});
    prev_valid <= hif.hdr_valid;
    prev_acc   <= hif.hdr_valid & hif.hdr_ready;
    prev_hdr   <= {hif.hdr_port, hif.hdr_session};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data_en = 1'b0;
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode == 1) idle(1);
    else if (gap_mode == 2) idle($urandom_range(0, 2));
    data_in = b;
    data_en = 1'b1;
    @(posedge clk); #1;
    bits_q.push_back(b);
    edge_q.push_back(cyc);
    data_en = 1'b0;
    data_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // p[i] is packet bit i in wire order.
  task automatic build_pkt(input logic [15:0] port, input logic [7:0] sess,
                           output logic [PKT_BITS-1:0] p);
    for (int i = 0; i < PKT_BITS; i++) p[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 16; k++) p[PORT_OFS + k] = port[15 - k];
    for (int k = 0; k < 8; k++) p[SESS_OFS + k] = sess[7 - k];
  endtask

  task automatic send_pkt(input logic [PKT_BITS-1:0] p, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(p[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    bits_q.delete(); edge_q.delete();
    start_q.delete(); done_q.delete(); pub_q.delete(); acc_q.delete();
    stab_base = stab_err;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".zero"},
          {23'd0, hif.hdr_valid, hif.hdr_port, hif.hdr_session, pkt_start, pkt_done,
           in_packet, dbg_state, 4'd0, pkt_cnt[3:0] == 4'd0 && pkt_cnt == 32'd0,
           overrun_cnt},
          {23'd0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'd0});
  endtask

  // ---------------- reference model ----------------
  // Scans the enabled-bit stream: a packet begins after SYNC_W fresh bits end
  // in the sync word; its next PKT_BITS bits are the packet, fields at fixed
  // offsets. Event times come from the edge that consumed the relevant bit.
  task automatic run_model(input bit ready_all);
    int n, i, fresh, p;
    logic [7:0]  win;
    logic [15:0] port;
    logic [7:0]  sess;
    logic [23:0] pubs[$];
    int          pubc[$];
    n = bits_q.size();
    i = 0; fresh = 0; win = '0;
    exp_start_q.delete(); exp_done_q.delete(); exp_pub_q.delete(); exp_q.delete();
    while (i < n) begin
      win = {win[6:0], bits_q[i]};
      fresh++;
      if (fresh >= 8 && win == SYNC) begin
        p = i + 1;
        exp_start_q.push_back(edge_q[i]);
        if (p + SESS_OFS + 7 < n) begin
          port = '0; sess = '0;
          for (int k = 0; k < 16; k++) port = {port[14:0], bits_q[p + PORT_OFS + k]};
          for (int k = 0; k < 8; k++) sess = {sess[6:0], bits_q[p + SESS_OFS + k]};
          pubs.push_back({port, sess});
          pubc.push_back(edge_q[p + SESS_OFS + 7]);
        end
        if (p + PKT_BITS - 1 < n) exp_done_q.push_back(edge_q[p + PKT_BITS - 1]);
        i = p + PKT_BITS;
        fresh = 0;
        win = '0;
      end else begin
        i++;
      end
    end
    if (ready_all) begin
      exp_q = pubs;
      exp_pub_q = pubc;
      exp_ovr = 0;
    end else begin
      exp_ovr = 0;
      if (pubs.size() > 0) begin
        exp_q.push_back(pubs[0]);
        exp_pub_q.push_back(pubc[0]);
        exp_ovr = (pubs.size() - 1 > 255) ? 255 : pubs.size() - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".n_start"}, start_q.size(), exp_start_q.size());
    for (int k = 0; k < start_q.size() && k < exp_start_q.size(); k++)
      check($sformatf("%s.start[%0d]", tag, k), start_q[k], exp_start_q[k]);
    check({tag, ".n_done"}, done_q.size(), exp_done_q.size());
    for (int k = 0; k < done_q.size() && k < exp_done_q.size(); k++)
      check($sformatf("%s.done[%0d]", tag, k), done_q[k], exp_done_q[k]);
    check({tag, ".n_pub"}, pub_q.size(), exp_pub_q.size());
    for (int k = 0; k < pub_q.size() && k < exp_pub_q.size(); k++)
      check($sformatf("%s.pub[%0d]", tag, k), pub_q[k], exp_pub_q[k]);
    check({tag, ".n_acc"}, acc_q.size(), exp_q.size());
    for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s.hdr[%0d]", tag, k), acc_q[k], exp_q[k]);
    check({tag, ".pkt_cnt"}, pkt_cnt, exp_start_q.size());
    check({tag, ".overrun"}, overrun_cnt, exp_ovr);
    check({tag, ".stable"}, stab_err - stab_base, 0);
  endtask

  function automatic logic [63:0] acc_port(input int k);
    return (acc_q.size() > k) ? 64'(acc_q[k][23:8]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] acc_sess(input int k);
    return (acc_q.size() > k) ? 64'(acc_q[k][7:0]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] span0();
    return (start_q.size() > 0 && done_q.size() > 0) ? 64'(done_q[0] - start_q[0])
                                                     : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // ---------------- directed sequence ----------------
  logic [PKT_BITS-1:0] pkt_a, pkt_b;
  logic [7:0]          sv;

  initial begin
    hif.hdr_ready = 1'b1;
    sv = SYNC;

    // Test 1: basic packet, port 23 / session 0x3C, continuous enable.
    gap_mode = 0;
    do_reset();
    check_reset_outputs("t1.reset");
    clear_logs();
    build_pkt(16'd23, 8'h3C, pkt_a);
    send_byte(8'h00);
    send_byte(SYNC);
    check("t1.in_packet", in_packet, 1'b1);
    send_pkt(pkt_a, PKT_BITS);
    idle(4);
    check("t1.in_packet_after", in_packet, 1'b0);
    run_model(1'b1);
    compare_all("t1");
    check("t1.port", acc_port(0), 64'd23);
    check("t1.sess", acc_sess(0), 64'h3C);
    check("t1.span", span0(), 64'd256);
    check("t1.valid_low", hif.hdr_valid, 1'b0);

    // Test 2: same packet, data_en toggling every cycle.
    gap_mode = 1;
    do_reset();
    clear_logs();
    send_byte(8'h00);
    send_byte(SYNC);
    send_pkt(pkt_a, PKT_BITS);
    idle(6);
    run_model(1'b1);
    compare_all("t2");
    check("t2.port", acc_port(0), 64'd23);
    check("t2.sess", acc_sess(0), 64'h3C);
    check("t2.span", span0(), 64'd512);

    // Test 3: back-to-back packets with the classifier stalled.
    gap_mode = 0;
    hif.hdr_ready = 1'b0;
    do_reset();
    clear_logs();
    build_pkt(16'd443, 8'($urandom_range(0, 255)), pkt_a);
    build_pkt(16'd22, 8'($urandom_range(0, 255)), pkt_b);
    send_byte(8'h00);
    send_byte(SYNC);
    send_pkt(pkt_a, PKT_BITS);
    send_byte(SYNC);
    send_pkt(pkt_b, PKT_BITS);
    idle(4);
    check("t3.valid_held", hif.hdr_valid, 1'b1);
    check("t3.port_held", hif.hdr_port, 16'd443);
    check("t3.overrun", overrun_cnt, 8'd1);
    hif.hdr_ready = 1'b1;
    idle(3);
    check("t3.valid_dropped", hif.hdr_valid, 1'b0);
    run_model(1'b0);
    compare_all("t3");
    check("t3.acc_port", acc_port(0), 64'd443);

    // Test 4: sync pattern embedded in payload, random enable gaps.
    gap_mode = 2;
    do_reset();
    clear_logs();
    build_pkt(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), pkt_a);
    for (int k = 0; k < 8; k++) begin
      pkt_a[10 + k]  = sv[7 - k];
      pkt_a[200 + k] = sv[7 - k];
      pkt_a[248 + k] = sv[7 - k];
    end
    send_byte(8'h00);
    send_byte(SYNC);
    send_pkt(pkt_a, PKT_BITS);
    send_byte(8'h00);
    idle(4);
    run_model(1'b1);
    compare_all("t4");
    check("t4.pkt_cnt", pkt_cnt, 32'd1);

    // Test 5: reset mid-packet, then a clean packet with port 161.
    gap_mode = 0;
    do_reset();
    clear_logs();
    build_pkt(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), pkt_a);
    send_byte(8'h00);
    send_byte(SYNC);
    send_pkt(pkt_a, 100);
    do_reset();
    check_reset_outputs("t5.reset");
    idle(3);
    check("t5.no_done", done_q.size(), 0);
    check("t5.one_start", start_q.size(), 1);
    clear_logs();
    build_pkt(16'd161, 8'($urandom_range(0, 255)), pkt_b);
    send_byte(SYNC);
    send_pkt(pkt_b, PKT_BITS);
    idle(4);
    run_model(1'b1);
    compare_all("t5");
    check("t5.port", acc_port(0), 64'd161);
    check("t5.pkt_cnt", pkt_cnt, 32'd1);

    // Test 6: 1010 followed by A5A5; framing starts at the first full A5.
    do_reset();
    clear_logs();
    build_pkt(16'hBEEF, 8'h5A, pkt_a);
    for (int k = 0; k < 8; k++) pkt_a[k] = sv[7 - k];
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_byte(SYNC);
    send_pkt(pkt_a, PKT_BITS);
    idle(4);
    run_model(1'b1);
    compare_all("t6");
    check("t6.port", acc_port(0), 64'hBEEF);
    check("t6.sess", acc_sess(0), 64'h5A);
    check("t6.pkt_cnt", pkt_cnt, 32'd1);

    // Randomized packets: random fields, prefix noise-free lead-in, enable gaps.
    for (int r = 0; r < 3; r++) begin
      gap_mode = $urandom_range(0, 2);
      do_reset();
      clear_logs();
      build_pkt(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), pkt_a);
      for (int z = 0; z < $urandom_range(0, 12); z++) send_bit(1'b0);
      send_byte(SYNC);
      send_pkt(pkt_a, PKT_BITS);
      idle(5);
      run_model(1'b1);
      compare_all($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
